ir_fetch: RTL and testbench



---
 rtl/cmd_pkg.sv | 29 ++
 rtl/fetch_timeout.sv | 43 ++++
 rtl/ir_fetch.sv | 161 ++++++++++++++++
 tb/tb_ir_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
//   Shared definitions for the manual-step command datapath.
//   - Fetch FSM state encoding (IDLE / REQ / DONE).
//   - Bit positions of the instruction fields inside a 16-bit word.
//   - Default address / data widths and fetch timeout.
// -----------------------------------------------------------------------------
package cmd_pkg;

  // Fetch FSM encoding. Kept as plain 2-bit constants so the state register
  // matches the legacy command-path blocks bit for bit.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // Instruction word layout: [15:12] opcode, [11:8] destination, [7:0] immediate.
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int DST_HI = 11;
  localparam int DST_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Default geometry of the fetch path.
  localparam int DEF_AW      = 8;
  localparam int DEF_DW      = 16;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/fetch_timeout.sv
// -----------------------------------------------------------------------------
// fetch_timeout
//   Wait-cycle counter for an outstanding ROM read. Counts the cycles a
//   request has been held; expired flags the last permitted cycle.
//
// Ports
//   clk     in   system clock
//   pc_clr  in   asynchronous active-low reset
//   clr     in   restart the count at zero (new request launched)
//   en      in   advance the count by one (request still waiting)
//   expired out  count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module fetch_timeout
  import cmd_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic pc_clr,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] tcnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or negedge pc_clr) begin
    if (!pc_clr) begin
      tcnt <= '0;
    end else if (clr) begin
      tcnt <= '0;
    end else if (en) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  // The request is dropped on the edge that ends the cycle where this is
  // high, so the read stays up for exactly TIMEOUT cycles (counts 0..TIMEOUT-1).
  assign expired = (tcnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/ir_fetch.sv
// -----------------------------------------------------------------------------
// ir_fetch
//   Instruction-fetch reader. Watches the program counter and issues one ROM
//   read for every distinct PC value, holds the request until the ROM
//   acknowledges (or the wait times out), latches the word into the
//   instruction register and announces it with a one-cycle ir_valid pulse.
//
// Ports
//   clk        in        system clock, rising edge
//   pc_clr     in        asynchronous active-low reset (shared with PC block)
//   pc         in  AW    current program counter
//   rom_addr   out AW    fetch address, frozen while rom_rd is high
//   rom_rd     out       read request level
//   rom_data   in  DW    read data, valid with rom_ack
//   rom_ack    in        single-cycle read acknowledge
//   ir         out DW    instruction register
//   ir_valid   out       one-cycle pulse: ir holds a new word
//   opcode     out 4     ir[15:12]
//   dst        out 4     ir[11:8]
//   imm        out 8     ir[7:0]
//   busy       out       FSM is not idle
//   fetch_err  out       sticky: last fetch timed out
// -----------------------------------------------------------------------------
module ir_fetch
  import cmd_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          pc_clr,
  input  logic [AW-1:0] pc,
  output logic [AW-1:0] rom_addr,
  output logic          rom_rd,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ack,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  output logic [3:0]    opcode,
  output logic [3:0]    dst,
  output logic [7:0]    imm,
  output logic          busy,
  output logic          fetch_err
);

  logic [1:0]    state;
  logic [AW-1:0] fetched_addr;
  logic          first;

  logic          need_fetch;
  logic          tmr_clr;
  logic          tmr_en;
  logic          expired;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    need_fetch = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;

    // After reset the current PC is always fetched, even if it happens to
    // match the (reset) fetched_addr.
    need_fetch = first || (pc != fetched_addr);

    if (state == IDLE) begin
      tmr_clr = need_fetch;
    end

    // Count only while genuinely waiting; an ack or the final cycle ends the
    // request, and the next launch clears the counter anyway.
    if (state == REQ) begin
      tmr_en = !rom_ack && !expired;
    end
  end

  fetch_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .pc_clr  (pc_clr),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  // ---------------------------------------------------------------------------
  // Fetch FSM and output registers
  // ---------------------------------------------------------------------------
  // NOTE: ir is an ordinary register (not a memory array), so it takes a reset
  // value like everything else; a reset mid-fetch must never expose a stale or
  // half-written word.
  always_ff @(posedge clk or negedge pc_clr) begin
    if (!pc_clr) begin
      state        <= IDLE;
      fetched_addr <= '0;
      first        <= 1'b1;
      rom_addr     <= '0;
      rom_rd       <= 1'b0;
      ir           <= '0;
      ir_valid     <= 1'b0;
      fetch_err    <= 1'b0;
    end else begin
      // ir_valid is a pulse: it is only ever set on the REQ->DONE edge.
      ir_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (need_fetch) begin
            rom_addr     <= pc;
            fetched_addr <= pc;
            first        <= 1'b0;
            rom_rd       <= 1'b1;
            state        <= REQ;
          end
        end

        // pc is deliberately not looked at here; any change made while the
        // request is outstanding is picked up once the FSM is back in IDLE.
        REQ: begin
          if (rom_ack) begin
            ir        <= rom_data;
            rom_rd    <= 1'b0;
            fetch_err <= 1'b0;
            ir_valid  <= 1'b1;
            state     <= DONE;
          end else if (expired) begin
            // Abandon the fetch. fetched_addr already holds this address, so
            // it is not retried until pc moves to a different value.
            rom_rd    <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IDLE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          rom_rd <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status and field decode
  // ---------------------------------------------------------------------------
  assign busy   = (state != IDLE);

  assign opcode = ir[OP_HI:OP_LO];
  assign dst    = ir[DST_HI:DST_LO];
  assign imm    = ir[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_ir_fetch.sv
// -----------------------------------------------------------------------------
// tb_ir_fetch
//   Directed bench for ir_fetch (TIMEOUT = 4). A table of single-fetch
//   vectors is applied in a loop; hand-written sequences cover reset, PC
//   changes during an outstanding request, stray acks and reset mid-fetch.
//   Inputs change 1 time unit after the rising edge, outputs are observed at
//   that same point (cycle k = k-th rising edge after the trigger).
// -----------------------------------------------------------------------------
module tb_ir_fetch;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        pc_clr = 1'b0;
  logic [7:0]  pc = 8'h00;
  logic [15:0] rom_data = 16'h0000;
  logic        rom_ack = 1'b0;

  logic [7:0]  rom_addr;
  logic        rom_rd;
  logic [15:0] ir;
  logic        ir_valid;
  logic [3:0]  opcode;
  logic [3:0]  dst;
  logic [7:0]  imm;
  logic        busy;
  logic        fetch_err;

  ir_fetch #(
    .AW      (8),
    .DW      (16),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .pc_clr    (pc_clr),
    .pc        (pc),
    .rom_addr  (rom_addr),
    .rom_rd    (rom_rd),
    .rom_data  (rom_data),
    .rom_ack   (rom_ack),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .opcode    (opcode),
    .dst       (dst),
    .imm       (imm),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scripted ROM responder / observer
  // ---------------------------------------------------------------------------
  int          delay_q[$];   // per request: wait cycles before ack, -1 = never
  logic [15:0] data_q[$];    // per request: word returned
  int          pcs_cyc[$];   // pc script: cycle index
  logic [7:0]  pcs_val[$];   // pc script: value applied at that cycle

  logic [7:0]  run_addr[$];  // address at start of each rom_rd run
  int          run_len[$];   // length of each rom_rd run in cycles
  int          run_start[$]; // cycle at which each run began
  int          valid_cyc[$]; // cycles with ir_valid high
  bit          addr_moved;   // rom_addr changed inside a run
  int          err_cycle;    // first cycle fetch_err rose, -1 if never

  task automatic arm();
    delay_q.delete();
    data_q.delete();
    pcs_cyc.delete();
    pcs_val.delete();
    run_addr.delete();
    run_len.delete();
    run_start.delete();
    valid_cyc.delete();
    addr_moved = 1'b0;
    err_cycle  = -1;
  endtask

  // Caller must already be 1 time unit after a rising edge (cycle 0).
  task automatic run_window(input int n);
    bit          prev_rd;
    bit          prev_err;
    int          cur_delay;
    logic [15:0] cur_data;
    int          last;
    prev_rd   = rom_rd;
    prev_err  = fetch_err;
    cur_delay = -1;
    cur_data  = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < pcs_cyc.size(); i++) begin
        if (pcs_cyc[i] == k) pc = pcs_val[i];
      end
      rom_ack = 1'b0;
      if (rom_rd) begin
        if (!prev_rd) begin
          last = run_addr.size();
          run_addr.push_back(rom_addr);
          run_len.push_back(1);
          run_start.push_back(k);
          cur_delay = (last < delay_q.size()) ? delay_q[last] : -1;
          cur_data  = (last < data_q.size()) ? data_q[last] : 16'h0000;
        end else begin
          last = run_len.size() - 1;
          run_len[last] = run_len[last] + 1;
          if (rom_addr !== run_addr[last]) addr_moved = 1'b1;
        end
        last = run_len.size() - 1;
        if (cur_delay >= 0 && run_len[last] == cur_delay + 1) begin
          rom_ack  = 1'b1;
          rom_data = cur_data;
        end
      end
      if (ir_valid) valid_cyc.push_back(k);
      if (fetch_err && !prev_err && err_cycle < 0) err_cycle = k;
      prev_rd  = rom_rd;
      prev_err = fetch_err;
    end
    rom_ack = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Single-fetch vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [7:0]  pc;
    int          delay;    // -1: ROM never acks
    logic [15:0] data;
    int          exp_rd;   // rom_rd high cycles
    int          exp_lat;  // cycle of ir_valid after pc change, 0 = none
    logic [15:0] exp_ir;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] e;

    vecs[0] = '{"step_0_1",  8'h01,  3, 16'h1234, 4, 5, 16'h1234, 1'b0};
    vecs[1] = '{"step_1_2",  8'h02,  0, 16'hF00D, 1, 2, 16'hF00D, 1'b0};
    vecs[2] = '{"timeout",   8'h03, -1, 16'hEEEE, 4, 0, 16'hF00D, 1'b1};
    vecs[3] = '{"err_clear", 8'h04,  1, 16'h7E81, 2, 3, 16'h7E81, 1'b0};
    vecs[4] = '{"jump_ff",   8'hFF,  2, 16'h0BAD, 3, 4, 16'h0BAD, 1'b0};
    vecs[5] = '{"wrap_00",   8'h00,  0, 16'hC3A5, 1, 2, 16'hC3A5, 1'b0};
    vecs[6] = '{"back_ff",   8'hFF,  0, 16'h5A5A, 1, 2, 16'h5A5A, 1'b0};

    // ---- reset state ----
    pc_clr = 1'b0;
    pc     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_rd",    32'(rom_rd),    0);
    check("rst_rom_addr",  32'(rom_addr),  0);
    check("rst_ir",        32'(ir),        0);
    check("rst_ir_valid",  32'(ir_valid),  0);
    check("rst_fetch_err", 32'(fetch_err), 0);
    check("rst_busy",      32'(busy),      0);

    // ---- first fetch after reset release, immediate ack ----
    arm();
    delay_q.push_back(0);
    data_q.push_back(16'hA35C);
    pc_clr = 1'b1;
    run_window(6);
    check("boot_runs",    run_addr.size(), 1);
    if (run_addr.size() > 0) begin
      check("boot_addr",  32'(run_addr[0]), 0);
      check("boot_len",   run_len[0], 1);
      check("boot_start", run_start[0], 1);
    end
    check("boot_valids",  valid_cyc.size(), 1);
    if (valid_cyc.size() > 0) check("boot_lat", valid_cyc[0], 2);
    check("boot_opcode",  32'(opcode), 'hA);
    check("boot_dst",     32'(dst),    'h3);
    check("boot_imm",     32'(imm),    'h5C);
    check("boot_busy",    32'(busy),   0);

    // ---- table of single fetches ----
    for (int i = 0; i < 7; i++) begin
      arm();
      pcs_cyc.push_back(0);
      pcs_val.push_back(vecs[i].pc);
      delay_q.push_back(vecs[i].delay);
      data_q.push_back(vecs[i].data);
      @(posedge clk);
      #1;
      run_window(10);
      e = vecs[i].exp_ir;
      check({vecs[i].name, "_runs"}, run_addr.size(), 1);
      if (run_addr.size() > 0) begin
        check({vecs[i].name, "_addr"},  32'(run_addr[0]), 32'(vecs[i].pc));
        check({vecs[i].name, "_start"}, run_start[0], 1);
        check({vecs[i].name, "_rdlen"}, run_len[0], vecs[i].exp_rd);
      end
      check({vecs[i].name, "_addr_hold"}, 32'(addr_moved), 0);
      check({vecs[i].name, "_valids"}, valid_cyc.size(), (vecs[i].exp_lat > 0) ? 1 : 0);
      if (vecs[i].exp_lat > 0 && valid_cyc.size() > 0)
        check({vecs[i].name, "_lat"}, valid_cyc[0], vecs[i].exp_lat);
      check({vecs[i].name, "_ir"},     32'(ir),     32'(e));
      check({vecs[i].name, "_opcode"}, 32'(opcode), 32'(e[15:12]));
      check({vecs[i].name, "_dst"},    32'(dst),    32'(e[11:8]));
      check({vecs[i].name, "_imm"},    32'(imm),    32'(e[7:0]));
      check({vecs[i].name, "_err"},    32'(fetch_err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_err)
        check({vecs[i].name, "_err_cycle"}, err_cycle, vecs[i].exp_rd + 1);
      check({vecs[i].name, "_busy"},   32'(busy), 0);
    end

    // ---- stray ack while idle is ignored ----
    @(posedge clk);
    #1;
    rom_ack  = 1'b1;
    rom_data = 16'hDEAD;
    @(posedge clk);
    #1;
    rom_ack = 1'b0;
    check("stray_ack_rd",    32'(rom_rd),   0);
    check("stray_ack_valid", 32'(ir_valid), 0);
    check("stray_ack_ir",    32'(ir),       'h5A5A);

    // ---- pc 1->2->3 style: changes during REQ, only the last is fetched ----
    arm();
    pcs_cyc.push_back(0); pcs_val.push_back(8'h10);
    pcs_cyc.push_back(2); pcs_val.push_back(8'h11);
    pcs_cyc.push_back(3); pcs_val.push_back(8'h12);
    delay_q.push_back(3); data_q.push_back(16'h1111);
    delay_q.push_back(0); data_q.push_back(16'h2222);
    @(posedge clk);
    #1;
    run_window(12);
    check("busy_chg_runs", run_addr.size(), 2);
    if (run_addr.size() == 2) begin
      check("busy_chg_addr0", 32'(run_addr[0]), 'h10);
      check("busy_chg_addr1", 32'(run_addr[1]), 'h12);
      check("busy_chg_len0",  run_len[0], 4);
      check("busy_chg_start1", run_start[1], 7);
    end
    check("busy_chg_hold", 32'(addr_moved), 0);
    check("busy_chg_valids", valid_cyc.size(), 2);
    if (valid_cyc.size() == 2) begin
      check("busy_chg_lat0", valid_cyc[0], 5);
      check("busy_chg_lat1", valid_cyc[1], 8);
    end
    check("busy_chg_ir", 32'(ir), 'h2222);

    // ---- pc returns to the in-flight address while busy: no refetch ----
    arm();
    pcs_cyc.push_back(0); pcs_val.push_back(8'h30);
    pcs_cyc.push_back(1); pcs_val.push_back(8'h31);
    pcs_cyc.push_back(2); pcs_val.push_back(8'h30);
    delay_q.push_back(2); data_q.push_back(16'h3C3C);
    @(posedge clk);
    #1;
    run_window(10);
    check("return_runs", run_addr.size(), 1);
    check("return_valids", valid_cyc.size(), 1);
    if (valid_cyc.size() > 0) check("return_lat", valid_cyc[0], 4);
    check("return_ir", 32'(ir), 'h3C3C);

    // ---- timeout, then reset in the middle of the next request ----
    arm();
    pcs_cyc.push_back(0); pcs_val.push_back(8'h40);
    delay_q.push_back(-1);
    @(posedge clk);
    #1;
    run_window(8);
    check("pre_rst_err", 32'(fetch_err), 1);
    check("pre_rst_ir",  32'(ir),        'h3C3C);

    arm();
    pcs_cyc.push_back(0); pcs_val.push_back(8'h20);
    delay_q.push_back(-1);
    @(posedge clk);
    #1;
    run_window(2);
    @(posedge clk);
    #1;
    check("mid_req_rd",   32'(rom_rd), 1);
    check("mid_req_addr", 32'(rom_addr), 'h20);
    pc_clr = 1'b0;
    #1;
    check("async_rst_rd",    32'(rom_rd),    0);
    check("async_rst_ir",    32'(ir),        0);
    check("async_rst_valid", 32'(ir_valid),  0);
    check("async_rst_busy",  32'(busy),      0);
    check("async_rst_err",   32'(fetch_err), 0);
    repeat (2) @(posedge clk);
    #1;

    arm();
    delay_q.push_back(0);
    data_q.push_back(16'h9ABC);
    pc_clr = 1'b1;
    run_window(6);
    check("refetch_runs", run_addr.size(), 1);
    if (run_addr.size() > 0) begin
      check("refetch_addr",  32'(run_addr[0]), 'h20);
      check("refetch_start", run_start[0], 1);
    end
    check("refetch_valids", valid_cyc.size(), 1);
    if (valid_cyc.size() > 0) check("refetch_lat", valid_cyc[0], 2);
    check("refetch_ir", 32'(ir), 'h9ABC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
